// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - N-approach actuated intersection phase controller
module traffic_phase_ctrl #(
  parameter int N_APPR    = 4,
  parameter int HOME      = 0,
  parameter int TICK_DIV  = 50000000,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [N_APPR-1:0]   req,
  output logic [2*N_APPR-1:0] light,
  output logic [2:0]          cur_appr,
  output logic [CNT_W-1:0]    remain,
  output logic [1:0]          state_o,
  output logic                phase_start
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] G_MIN      = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX      = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_T        = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_T       = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        cur_q, cur_d;
  logic [2:0]        nxt_q, nxt_d;
  logic [CNT_W-1:0]  elapsed_q, elapsed_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [N_APPR-1:0] pend_q, pend_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              phase_start_q, phase_start_d;

  logic              tick;
  logic [CNT_W-1:0]  elapsed_inc;
  logic [N_APPR-1:0] cur_mask, home_mask, nxt_mask, dem;
  logic              req_cur;
  logic [2:0]        pick;

  // Free-running prescaler; tick is the single cycle at the top of its count
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Demand vector with the home approach always requesting, and round-robin pick after cur
  always_comb begin
    cur_mask  = '0;
    home_mask = '0;
    nxt_mask  = '0;
    req_cur   = 1'b0;
    for (int i = 0; i < N_APPR; i++) begin
      cur_mask[i]  = (cur_q == 3'(i));
      nxt_mask[i]  = (nxt_q == 3'(i));
      home_mask[i] = (i == HOME);
      if (cur_q == 3'(i)) req_cur = req[i];
    end
    dem  = (pend_q | req | home_mask) & ~cur_mask;
    pick = cur_q;
    for (int k = N_APPR; k >= 1; k--) begin
      if (dem[(int'(cur_q) + k) % N_APPR]) pick = 3'((int'(cur_q) + k) % N_APPR);
    end
  end

  assign elapsed_inc = elapsed_q + ONE;

  // Phase sequencing: GREEN with gap-out/max-out, then timed YELLOW and ALLRED
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    nxt_d         = nxt_q;
    elapsed_d     = elapsed_q;
    timer_d       = timer_q;
    pend_d        = pend_q | req;
    phase_start_d = 1'b0;
    case (state_q)
      ST_GREEN: begin
        if (tick) begin
          if ((dem != '0) &&
              (((elapsed_inc >= G_MIN) && !req_cur) || (elapsed_inc >= G_MAX))) begin
            state_d = ST_YELLOW;
            timer_d = Y_T;
            nxt_d   = pick;
          end else begin
            elapsed_d = (elapsed_inc >= G_MAX) ? G_MAX : elapsed_inc;
          end
        end
      end
      ST_YELLOW: begin
        if (tick) begin
          if (timer_q == ONE) begin
            state_d = ST_ALLRED;
            timer_d = AR_T;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      ST_ALLRED: begin
        if (tick) begin
          if (timer_q == ONE) begin
            state_d       = ST_GREEN;
            cur_d         = nxt_q;
            elapsed_d     = '0;
            phase_start_d = 1'b1;
            pend_d        = (pend_q & ~nxt_mask) | req;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      default: begin
        state_d = ST_GREEN;
      end
    endcase
  end

  // State and timer registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_GREEN;
      cur_q         <= 3'(HOME);
      nxt_q         <= 3'(HOME);
      elapsed_q     <= '0;
      timer_q       <= '0;
      pend_q        <= '0;
      presc_q       <= '0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      nxt_q         <= nxt_d;
      elapsed_q     <= elapsed_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      presc_q       <= presc_d;
      phase_start_q <= phase_start_d;
    end
  end

  // Lamp codes: only the current approach may show G or Y, everything else red
  always_comb begin
    light = '0;
    for (int i = 0; i < N_APPR; i++) begin
      if ((cur_q == 3'(i)) && (state_q == ST_GREEN))       light[2*i +: 2] = 2'b00;
      else if ((cur_q == 3'(i)) && (state_q == ST_YELLOW)) light[2*i +: 2] = 2'b01;
      else                                                 light[2*i +: 2] = 2'b10;
    end
  end

  assign remain      = (state_q == ST_GREEN) ? (G_MAX - elapsed_q) : timer_q;
  assign state_o     = state_q;
  assign cur_appr    = cur_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [7:0] l1, l4;
  logic [2:0] ca1, ca4;
  logic [7:0] rm1, rm4;
  logic [1:0] st1, st4;
  logic       ps1, ps4;

  int n_cmp;
  int n_bad;

  traffic_phase_ctrl #(
    .N_APPR(4), .HOME(0), .TICK_DIV(1), .CNT_W(8),
    .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
  ) u1 (
    .CLOCK_50(clk), .reset(rst_n), .req(req), .light(l1), .cur_appr(ca1),
    .remain(rm1), .state_o(st1), .phase_start(ps1)
  );

  traffic_phase_ctrl #(
    .N_APPR(4), .HOME(0), .TICK_DIV(4), .CNT_W(8),
    .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
  ) u4 (
    .CLOCK_50(clk), .reset(rst_n), .req(req), .light(l4), .cur_appr(ca4),
    .remain(rm4), .state_o(st4), .phase_start(ps4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_light(input logic [1:0] st, input logic [2:0] ca);
    logic [7:0] l;
    for (int i = 0; i < 4; i++) begin
      if (ca == 3'(i) && st == 2'b00)      l[2*i +: 2] = 2'b00;
      else if (ca == 3'(i) && st == 2'b01) l[2*i +: 2] = 2'b01;
      else                                 l[2*i +: 2] = 2'b10;
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic exp_cyc(input string tag, input logic [1:0] st, input logic [2:0] ca,
                         input logic [7:0] rm, input logic ps);
    check_eq({tag, ".state"}, 32'(st1), 32'(st));
    check_eq({tag, ".cur"}, 32'(ca1), 32'(ca));
    check_eq({tag, ".remain"}, 32'(rm1), 32'(rm));
    check_eq({tag, ".pstart"}, 32'(ps1), 32'(ps));
    check_eq({tag, ".light"}, 32'(l1), 32'(exp_light(st, ca)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".light"}, 32'(l1), 32'h000000A8);
    check_eq({tag, ".state"}, 32'(st1), 32'd0);
    check_eq({tag, ".cur"}, 32'(ca1), 32'd0);
    check_eq({tag, ".remain"}, 32'(rm1), 32'd6);
    check_eq({tag, ".pstart"}, 32'(ps1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_light;
    int ps_cnt;
    int y_cnt;
    int pc_cyc[$];
    int pc_ca[$];
    int exp_cyc_tab[5];
    int exp_ca_tab[5];

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 4'b0000;

    // Idle: home rests green, no phase_start
    do_reset();
    check_reset_outputs("rst");
    bad_light = 0;
    ps_cnt    = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (l1 !== 8'b10101000) bad_light++;
      if (ps1) ps_cnt++;
    end
    check_eq("idle.light_changes", 32'(bad_light), 32'd0);
    check_eq("idle.pstart_pulses", 32'(ps_cnt), 32'd0);

    // Gap-out: pulse req[2], appr0 -> appr2 -> back to home
    do_reset();
    req = 4'b0100;
    step(); req = 4'b0000;
    exp_cyc("gap.p0", 2'b00, 3'd0, 8'd5, 1'b0);
    step(); exp_cyc("gap.p1", 2'b00, 3'd0, 8'd4, 1'b0);
    step(); exp_cyc("gap.p2", 2'b01, 3'd0, 8'd2, 1'b0);
    step(); exp_cyc("gap.p3", 2'b01, 3'd0, 8'd1, 1'b0);
    step(); exp_cyc("gap.p4", 2'b10, 3'd0, 8'd1, 1'b0);
    check_eq("gap.allred_light", 32'(l1), 32'h000000AA);
    step(); exp_cyc("gap.p5", 2'b00, 3'd2, 8'd6, 1'b1);
    check_eq("gap.g2_light", 32'(l1), 32'h0000008A);
    step(); exp_cyc("gap.p6", 2'b00, 3'd2, 8'd5, 1'b0);
    step(); exp_cyc("gap.p7", 2'b00, 3'd2, 8'd4, 1'b0);
    step(); exp_cyc("gap.p8", 2'b01, 3'd2, 8'd2, 1'b0);
    step(); exp_cyc("gap.p9", 2'b01, 3'd2, 8'd1, 1'b0);
    step(); exp_cyc("gap.p10", 2'b10, 3'd2, 8'd1, 1'b0);
    step(); exp_cyc("gap.p11", 2'b00, 3'd0, 8'd6, 1'b1);
    for (int c = 0; c < 10; c++) step();
    exp_cyc("gap.home_sat", 2'b00, 3'd0, 8'd0, 1'b0);

    // Max-out: req[1] held, req[3] pulsed while appr1 green
    do_reset();
    req = 4'b0010;
    step(); exp_cyc("max.p0", 2'b00, 3'd0, 8'd5, 1'b0);
    step();
    step(); exp_cyc("max.p2", 2'b01, 3'd0, 8'd2, 1'b0);
    step();
    step(); exp_cyc("max.p4", 2'b10, 3'd0, 8'd1, 1'b0);
    step(); exp_cyc("max.p5", 2'b00, 3'd1, 8'd6, 1'b1);
    req = 4'b1010;
    step(); exp_cyc("max.p6", 2'b00, 3'd1, 8'd5, 1'b0);
    req = 4'b0010;
    step(); exp_cyc("max.p7", 2'b00, 3'd1, 8'd4, 1'b0);
    step(); exp_cyc("max.p8", 2'b00, 3'd1, 8'd3, 1'b0);
    step(); exp_cyc("max.p9", 2'b00, 3'd1, 8'd2, 1'b0);
    step(); exp_cyc("max.p10", 2'b00, 3'd1, 8'd1, 1'b0);
    step(); exp_cyc("max.p11", 2'b01, 3'd1, 8'd2, 1'b0);
    step(); exp_cyc("max.p12", 2'b01, 3'd1, 8'd1, 1'b0);
    step(); exp_cyc("max.p13", 2'b10, 3'd1, 8'd1, 1'b0);
    step(); exp_cyc("max.p14", 2'b00, 3'd3, 8'd6, 1'b1);
    req = 4'b0000;

    // Round robin: req=1110 held, order 1,2,3,0,1 at fixed cycles
    exp_cyc_tab[0] = 5;  exp_ca_tab[0] = 1;
    exp_cyc_tab[1] = 14; exp_ca_tab[1] = 2;
    exp_cyc_tab[2] = 23; exp_ca_tab[2] = 3;
    exp_cyc_tab[3] = 32; exp_ca_tab[3] = 0;
    exp_cyc_tab[4] = 38; exp_ca_tab[4] = 1;
    do_reset();
    req = 4'b1110;
    for (int c = 0; c <= 44; c++) begin
      step();
      if (ps1) begin
        pc_cyc.push_back(c);
        pc_ca.push_back(int'(ca1));
      end
    end
    req = 4'b0000;
    check_eq("rr.count", 32'(pc_cyc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < pc_cyc.size()) begin
        check_eq($sformatf("rr.cycle%0d", i), 32'(pc_cyc[i]), 32'(exp_cyc_tab[i]));
        check_eq($sformatf("rr.appr%0d", i), 32'(pc_ca[i]), 32'(exp_ca_tab[i]));
      end
    end

    // Prescaled timing on the TICK_DIV=4 instance
    do_reset();
    req = 4'b0010;
    step(); req = 4'b0000;
    check_eq("div.q0_remain", 32'(rm4), 32'd6);
    y_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (st4 == 2'b01) y_cnt++;
      case (c)
        2:  check_eq("div.q2_remain", 32'(rm4), 32'd6);
        3:  check_eq("div.q3_remain", 32'(rm4), 32'd5);
        6:  check_eq("div.q6_remain", 32'(rm4), 32'd5);
        7:  check_eq("div.q7_remain", 32'(rm4), 32'd4);
        10: check_eq("div.q10_state", 32'(st4), 32'd0);
        11: begin
          check_eq("div.q11_state", 32'(st4), 32'd1);
          check_eq("div.q11_remain", 32'(rm4), 32'd2);
        end
        14: check_eq("div.q14_remain", 32'(rm4), 32'd2);
        15: check_eq("div.q15_remain", 32'(rm4), 32'd1);
        19: check_eq("div.q19_state", 32'(st4), 32'd2);
        23: begin
          check_eq("div.q23_pstart", 32'(ps4), 32'd1);
          check_eq("div.q23_cur", 32'(ca4), 32'd1);
        end
        default: ;
      endcase
    end
    check_eq("div.yellow_cycles", 32'(y_cnt), 32'd8);

    // Async reset during YELLOW of appr2 drops the pending req[3]
    do_reset();
    req = 4'b0100;
    step(); req = 4'b0000;
    step(); step(); step(); step();
    step(); exp_cyc("ar.p5", 2'b00, 3'd2, 8'd6, 1'b1);
    req = 4'b1000;
    step(); req = 4'b0000;
    step();
    step(); exp_cyc("ar.p8", 2'b01, 3'd2, 8'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("ar.async");
    step();
    rst_n = 1'b1;
    bad_light = 0;
    ps_cnt    = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (l1 !== 8'b10101000) bad_light++;
      if (ps1) ps_cnt++;
    end
    check_eq("ar.light_changes", 32'(bad_light), 32'd0);
    check_eq("ar.pstart_pulses", 32'(ps_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-approach actuated intersection controller that generalises the two-road highway/country controller. It serves any number of approaches round-robin and holds a configurable home approach green when there is no demand. Each green phase has min/max green and demand extension, followed by yellow and all-red clearance. All timing is internal, driven by a prescaled tick, so no external counter handshake is needed. It sits between the debounced sensor inputs and the lamp drivers and 7-segment status display.

Parameters:
N_APPR, 4, number of approaches (2..8)
HOME, 0, approach that rests green with no demand (0..N_APPR-1)
TICK_DIV, 50000000, CLOCK_50 cycles per timing tick (>=1; 1 = tick every cycle)
CNT_W, 8, width of the tick counters
GREEN_MIN, 10, minimum green in ticks (>=1)
GREEN_MAX, 30, maximum green in ticks (>=GREEN_MIN)
YELLOW_T, 5, yellow duration in ticks (>=1)
ALLRED_T, 2, all-red clearance in ticks (>=1)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  N_APPR  level vehicle/pedestrian demand per approach
light  out  2*N_APPR  lamp code per approach, [2i+1:2i]; G=00, Y=01, R=10
cur_appr  out  3  approach currently green/yellow
remain  out  CNT_W  ticks left in current timed interval
state_o  out  2  GREEN=00, YELLOW=01, ALLRED=10
phase_start  out  1  one-cycle pulse when a new GREEN begins

Behaviour:
- Reset (async, active low): state GREEN, cur_appr=HOME, elapsed=0, pend=0, prescaler=0. light: HOME=G, others=R. remain=GREEN_MAX, phase_start=0. Exiting reset produces no phase_start.
- Tick: prescaler counts 0..TICK_DIV-1; tick=1 for the single cycle at TICK_DIV-1. All timers advance only on tick. Prescaler runs freely in every state.
- pend register: pend <= pend | req every cycle. The bit for the new approach is cleared on the cycle GREEN is entered, and req is OR-ed after that clear, so a held req re-latches.
- dem = (pend | req | (1<<HOME)) with bit cur_appr masked off. HOME is treated as always requesting.
- GREEN:
  - cur_appr=G, others=R. elapsed increments on tick, saturating at GREEN_MAX. remain = GREEN_MAX - elapsed.
  - The exit check is evaluated on a tick using e = elapsed+1, and requires dem != 0.
  - Gap-out: e >= GREEN_MIN and req[cur_appr]=0.
  - Max-out: e >= GREEN_MAX, regardless of req[cur_appr].
  - If dem = 0, stay green indefinitely. This can only happen when cur_appr=HOME.
  - On exit, latch nxt = first set bit of dem searching cur_appr+1, cur_appr+2, … modulo N_APPR. Go to YELLOW.
- YELLOW: load timer=YELLOW_T. cur_appr=Y, others=R. Decrement on tick; leave for ALLRED on the tick where timer==1. Lasts exactly YELLOW_T ticks.
- ALLRED: load timer=ALLRED_T. All approaches R. On the tick where timer==1: cur_appr<=nxt, elapsed<=0, state GREEN, phase_start=1 for one cycle.
- remain shows the timer value in YELLOW/ALLRED.
- Demand arriving during YELLOW/ALLRED is latched in pend but does not change nxt.
- Simultaneous req rise and exit tick: the request is included in dem for that exit decision.
- At most one approach is non-R at any cycle. Transitions G->R or R->G without Y/ALLRED are illegal.
- Reset asserted mid-phase returns immediately to the reset state and clears pend.

Test Plan:
(Common settings: TICK_DIV=1, N_APPR=4, HOME=0, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1.)
1. Idle: no req for 50 cycles after reset -> light=8'b10101000 (appr0 G) constant, phase_start never pulses.
2. Gap-out: 1-cycle pulse on req[2] at cycle 0 -> appr0 G for 3 ticks, Y 2, all-R 1. Then appr2 G with phase_start=1. With no further demand, appr2 gaps out after 3 ticks, goes Y/all-R, and returns to appr0.
3. Max-out: req[1] held high plus req[3] pulsed while appr1 is green -> appr1 G for exactly 6 ticks, then Y/all-R, then appr3 green.
4. Round robin: req=4'b1110 held from reset -> green order 0,1,2,3,0,1… Each non-home green lasts 6 ticks; no approach is skipped.
5. TICK_DIV=4 with req[1] pulsed -> YELLOW lasts exactly 8 cycles, and remain decrements once per 4 cycles.
6. reset dropped during YELLOW of appr2 -> outputs reset values asynchronously; the pending req[3] latched before reset is lost.
